latency_ram: RTL

//  Word-addressed RAM with programmable access latency. Sits directly downstream of the
//  CPU top's RAM port (cpu_ram_if ram side): takes memaddr/memstore/memREN/memWEN, returns

---
 rtl/cpu_types_pkg.sv | 30 +++
 rtl/latency_ram_lat_counter.sv | 38 +++
 rtl/latency_ram.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word, RAM handshake state, RAM FSM state, request key.
// No logic. No latency. No backpressure.
// Imported by latency_ram and its latency counter.
package cpu_types_pkg;

    localparam int RAM_LAT_W = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ramfsm_t;

    // Identity of an outstanding request; any change restarts the wait.
    typedef struct packed {
        logic [29:0] waddr;
        logic        ren;
        logic        wen;
    } ramkey_t;

endpackage

// File: rtl/latency_ram_lat_counter.sv
// Wait-state counter: load to 1, increment, flag when the count reaches LAT.
// Latency: count updates on the rising edge; done is combinational from the count.
// Backpressure: none; the owning FSM decides when to load or increment.
module lat_counter
    import cpu_types_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic inc,
    output logic done
);

    localparam int LAT_MAX = (1 << RAM_LAT_W) - 1;

    if (LAT < 0 || LAT > LAT_MAX) begin : g_bad_lat
        $error("lat_counter: LAT must be in 0..15");
    end

    localparam logic [RAM_LAT_W-1:0] LAT_V = RAM_LAT_W'(LAT);

    logic [RAM_LAT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RAM_LAT_W'(1);
        end else if (inc) begin
            cnt <= cnt + RAM_LAT_W'(1);
        end
    end

    assign done = (cnt == LAT_V);

endmodule

// File: rtl/latency_ram.sv
// Word-addressed RAM with LAT wait states ahead of each access; optional stats via RAM_STATS_EN.
// Latency: ACCESS LAT cycles after the request is first seen, then one forced FREE cycle.
// Backpressure: requester holds memREN/memWEN until ACCESS; BUSY/FREE mean wait.
module latency_ram
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic      CLK,
    input  logic      RST,
    input  word_t     memaddr,
    input  word_t     memstore,
    input  logic      memREN,
    input  logic      memWEN,
    output word_t     ramload,
    output ramstate_t ramstate
`ifdef RAM_STATS_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic [31:0] err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    word_t          mem [DEPTH];
    ramfsm_t        fsm, fsm_nxt;
    ramkey_t        key, key_q;
    logic           key_ld, cnt_load, cnt_inc, cnt_done;
    logic           req, err;
    logic [AW-1:0]  idx;
    logic           unused_addr_lsb;

    assign unused_addr_lsb = ^memaddr[1:0];
    assign idx = memaddr[AW+1:2];
    assign req = memREN ^ memWEN;
    assign err = (memREN & memWEN) | (memaddr[31:2] >= 30'(DEPTH));
    assign key = '{waddr: memaddr[31:2], ren: memREN, wen: memWEN};

    lat_counter #(.LAT(LAT)) u_lat_counter (
        .CLK  (CLK),
        .RST  (RST),
        .load (cnt_load),
        .inc  (cnt_inc),
        .done (cnt_done)
    );

    // ACCESS and ERROR must be visible in the cycle they arise, so ramstate is combinational.
    always_comb begin
        ramstate = FREE;
        fsm_nxt  = fsm;
        key_ld   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        if (err) begin
            ramstate = ERROR;
            fsm_nxt  = IDLE;
        end else begin
            case (fsm)
                IDLE: begin
                    if (req) begin
                        if (LAT == 0) begin
                            ramstate = ACCESS;
                            fsm_nxt  = DONE;
                        end else begin
                            ramstate = BUSY;
                            key_ld   = 1'b1;
                            cnt_load = 1'b1;
                            fsm_nxt  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        fsm_nxt = IDLE;
                    end else if (key != key_q) begin
                        ramstate = BUSY;
                        key_ld   = 1'b1;
                        cnt_load = 1'b1;
                    end else if (cnt_done) begin
                        ramstate = ACCESS;
                        fsm_nxt  = DONE;
                    end else begin
                        ramstate = BUSY;
                        cnt_inc  = 1'b1;
                    end
                end
                DONE: begin
                    fsm_nxt = IDLE;
                end
                default: begin
                    fsm_nxt = IDLE;
                end
            endcase
        end
        if (RST) begin
            ramstate = FREE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm   <= IDLE;
            key_q <= '0;
        end else begin
            fsm <= fsm_nxt;
            if (key_ld) begin
                key_q <= key;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ramstate == ACCESS && memWEN) begin
            mem[idx] <= memstore;
        end
    end

    assign ramload = (ramstate == ACCESS && memREN) ? mem[idx] : '0;

`ifdef RAM_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (ramstate == ACCESS && memREN) rd_cnt  <= rd_cnt + 32'd1;
            if (ramstate == ACCESS && memWEN) wr_cnt  <= wr_cnt + 32'd1;
            if (ramstate == ERROR)            err_cnt <= err_cnt + 32'd1;
        end
    end
`endif

endmodule
